fetch_line_buffer: RTL
======================

FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus data width (only 64 supported).
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port entry, input, 64, program entry PC, sampled during reset.
REQ-006 SHALL have ports bus_reqcyc (out, 1), bus_req (out, BUS_DATA_WIDTH), bus_reqtag (out, BUS_TAG_WIDTH), bus_reqack (in, 1): Sysbus request channel.
REQ-007 SHALL have ports bus_respcyc (in, 1), bus_resp (in, BUS_DATA_WIDTH), bus_resptag (in, BUS_TAG_WIDTH, ignored), bus_respack (out, 1): Sysbus response channel.
REQ-008 SHALL have ports redirect_valid (in, 1), redirect_pc (in, 64): fetch redirect from downstream.
REQ-009 SHALL have ports insn_valid (out, 1), insn_ready (in, 1), insn (out, 32), insn_pc (out, 64): instruction stream to decode.
REQ-010 SHALL have port halt, output, 1: fetch stopped (see Configuration).

Function
REQ-011 SHALL implement states IDLE, REQ, FILL, DRAIN, FLUSH, HALT.
REQ-012 IDLE: one cycle after reset release, then REQ.
REQ-013 REQ: bus_reqcyc=1, bus_req={pc[63:6],6'b0}, bus_reqtag={`SYSBUS_READ,`SYSBUS_MEMORY,8'b0}; req fields held stable until bus_reqack; on bus_reqack -> FILL, beat counter=0.
REQ-014 FILL: each cycle with bus_respcyc=1, bus_respack=1 combinationally same cycle, bus_resp stored as beat[counter], counter++; after beat 7 -> DRAIN with word index=pc[5:2].
REQ-015 Word mapping: word 2k = beat k[31:0], word 2k+1 = beat k[63:32]; 16 words per 64-byte line.
REQ-016 DRAIN: insn_valid=1, insn=word[index], insn_pc={line_base[63:6],index,2'b00}; insn/insn_pc held stable while insn_valid && !insn_ready.
REQ-017 On insn_valid && insn_ready: index++; if index was 15, pc=line_base+64 (modulo 2^64, wraps to 0) and -> REQ.
REQ-018 Latency: reqack at cycle T with back-to-back beats T+1..T+8 -> insn_valid at T+9.
REQ-019 Words below pc[5:2] in the first line after entry/redirect SHALL never be presented.
REQ-020 Redirect in DRAIN or REQ-without-ack: pc=redirect_pc, insn_valid=0 next cycle, -> REQ (new address presented next cycle).
REQ-021 Redirect in REQ with bus_reqack same cycle, or in FILL: pc=redirect_pc, -> FLUSH; FLUSH acks and discards remaining beats to total 8, then -> REQ.
REQ-022 Redirect simultaneous with insn_valid && insn_ready: handshake completes, redirect wins for next pc.
REQ-023 Redirect during HALT or FLUSH: pc updated, state transition unchanged (HALT stays HALT).
REQ-024 bus_respack SHALL be 0 outside FILL/FLUSH; bus_reqcyc SHALL be 0 outside REQ.

Reset
REQ-025 reset SHALL force state=IDLE, pc=entry, counter=0, index=0 next edge.
REQ-026 Reset values: bus_reqcyc=0, bus_respack=0, bus_req=0, bus_reqtag=0, insn_valid=0, insn=0, insn_pc=0, halt=0.
REQ-027 Reset mid-burst SHALL abandon the burst; no further beats acknowledged until a new REQ.

Configuration
REQ-028 With FETCH_HALT_ON_ZERO_EN defined: an all-zero word at DRAIN index is not presented; halt=1, -> HALT, no further bus requests until reset.
REQ-029 Without FETCH_HALT_ON_ZERO_EN: zero words presented like any other; halt tied 0; HALT unreachable.

Verification
REQ-030 entry=0x1000, immediate reqack, beats 0x0000000200000001..0x000000100000000F -> bus_req=0x1000, insn 0x1..0x10 at insn_pc 0x1000..0x103C, then bus_req=0x1040.
REQ-031 entry=0x1028 -> bus_req=0x1000, first insn_pc=0x1028 (word 10), 6 words presented before next request.
REQ-032 insn_ready=0 for 5 cycles at word 3 -> insn/insn_pc unchanged for 5 cycles, no skipped words.
REQ-033 redirect_pc=0x2004 at FILL beat 3 -> beats 4..7 acked/discarded, next bus_req=0x2000, first insn_pc=0x2004.
REQ-034 pc=0xFFFFFFFFFFFFFFC0 line drained -> next bus_req=0x0.
REQ-035 FETCH_HALT_ON_ZERO_EN, word 5 = 0 -> words 0..4 presented, halt=1, bus_reqcyc stays 0; without macro word 5 presented as 0.

Source files
------------

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer: fetches 64-byte lines over Sysbus and streams 32-bit words to decode
// Ports: clk/reset (sync, active high), entry (start PC sampled in reset),
//   bus_req* request channel, bus_resp* response channel, redirect_valid/redirect_pc,
//   insn_valid/insn_ready/insn/insn_pc instruction stream, halt.
// Build option: define FETCH_HALT_ON_ZERO_EN to stop fetch at an all-zero word (halt=1).
`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif
module fetch_line_buffer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      insn_valid,
  input  logic                      insn_ready,
  output logic [31:0]               insn,
  output logic [63:0]               insn_pc,
  output logic                      halt
);
  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, FLUSH, HALT} state_e;
  state_e state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [BUS_DATA_WIDTH-1:0] beat_q [8];
  logic [31:0] word;
  logic zero_hit, fire, last, unused_ok;
  assign word = idx_q[0] ? beat_q[idx_q[3:1]][63:32] : beat_q[idx_q[3:1]][31:0];
`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_hit = state_q == DRAIN && word == '0;
  assign halt = state_q == HALT;
`else
  assign zero_hit = 1'b0;
  assign halt = 1'b0;
`endif
  assign insn_valid = state_q == DRAIN && !zero_hit;
  assign insn = insn_valid ? word : '0;
  assign insn_pc = insn_valid ? {pc_q[63:6], idx_q, 2'b00} : '0;
  assign bus_reqcyc = state_q == REQ;
  assign bus_req = bus_reqcyc ? BUS_DATA_WIDTH'({pc_q[63:6], 6'b0}) : '0;
  assign bus_reqtag = bus_reqcyc ? BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 8'b0}) : '0;
  assign bus_respack = bus_respcyc && (state_q == FILL || state_q == FLUSH);
  assign fire = insn_valid && insn_ready;
  assign last = fire && idx_q == 4'hf;
  assign unused_ok = ^{bus_resptag, pc_q[1:0]};
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus_reqack) cnt_d = '0;
        state_d = bus_reqack ? (redirect_valid ? FLUSH : FILL) : REQ;
      end
      FILL, FLUSH: begin
        // a redirect still has to drain the burst to 8 beats before re-requesting
        if (bus_respack) cnt_d = cnt_q + 3'd1;
        if (bus_respack && cnt_q == 3'd7) state_d = (state_q == FILL && !redirect_valid) ? DRAIN : REQ;
        else if (redirect_valid) state_d = FLUSH;
        idx_d = pc_q[5:2];
      end
      DRAIN: begin
        if (fire) idx_d = idx_q + 4'd1;
        if (last) pc_d = {pc_q[63:6] + 58'd1, 6'b0};
        state_d = (redirect_valid || last) ? REQ : zero_hit ? HALT : DRAIN;
      end
      default: ;
    endcase
    if (redirect_valid) pc_d = redirect_pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= entry;
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
    if (!reset && state_q == FILL && bus_respcyc) beat_q[cnt_q] <= bus_resp;
  end
endmodule
